// File: rtl/benes_route_ctrl_pkg.sv
// Shared parameters, types and helpers for the Benes route controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package benes_route_ctrl_pkg;

    localparam int SIZE       = 32;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    localparam int CFG_CTX    = 4;
    localparam int CTX_W      = $clog2(CFG_CTX);

    // Stage index width on the config port; must cover STAGE_NUM-1 and the
    // out-of-range values that raise cfg_err.
    localparam int STAGE_W    = 4;

    // In-flight counter must hold one count per pipeline entry plus headroom.
    localparam int CNT_W      = $clog2(STAGE_NUM + 2);

    // Context pipeline: one entry per stage plus the output-alignment entry.
    localparam int PIPE_DEPTH = STAGE_NUM + 1;

    typedef logic [CTX_W-1:0]      ctx_id_t;
    typedef logic [SWITCH_NUM-1:0] stage_cfg_t;
    typedef logic [STAGE_W-1:0]    stage_idx_t;
    typedef logic [STAGE_NUM-1:0]  stage_mask_t;
    typedef logic [CNT_W-1:0]      inflight_t;

    localparam stage_idx_t STAGE_LIMIT = stage_idx_t'(STAGE_NUM);

    typedef enum logic [1:0] {
        CTX_EMPTY   = 2'd0,
        CTX_PARTIAL = 2'd1,
        CTX_READY   = 2'd2
    } ctx_state_t;

    // One context-pipeline entry: a vector tag travelling alongside the data.
    typedef struct packed {
        logic    vld;
        ctx_id_t ctx;
    } pipe_ent_t;

    // Classify a context from its written-stage mask.
    function automatic ctx_state_t ctx_state(input stage_mask_t mask);
        ctx_state_t st;
        if (mask == '0) begin
            st = CTX_EMPTY;
        end else if (&mask) begin
            st = CTX_READY;
        end else begin
            st = CTX_PARTIAL;
        end
        return st;
    endfunction

    // True when a config stage index addresses a real stage.
    function automatic logic stage_in_range(input stage_idx_t stage);
        return stage < STAGE_LIMIT;
    endfunction

endpackage

// File: rtl/benes_cfg_bank.sv
// Context memory: per-context stage words, written-stage masks, ready flags.
// Latency: writes/clears land at the clock edge; reads are combinational.
// Backpressure: none; the caller decides when a write or clear may happen.
module benes_cfg_bank
    import benes_route_ctrl_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [CTX_W-1:0]                     wr_ctx,
    input  logic [STAGE_W-1:0]                   wr_stage,
    input  logic [SWITCH_NUM-1:0]                wr_bits,
    input  logic                                 clr_en,
    input  logic [CTX_W-1:0]                     clr_ctx,
    input  logic [STAGE_NUM-1:0][CTX_W-1:0]      rd_ctx,
    output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] rd_data,
    output logic [CFG_CTX-1:0]                   ctx_ready
);

    stage_cfg_t  mem  [CFG_CTX][STAGE_NUM];
    stage_mask_t mask [CFG_CTX];
    logic        wr_ok;

    // Out-of-range stage indices never touch memory or masks.
    assign wr_ok = wr_en && stage_in_range(wr_stage);

    // Stage word storage; contents survive a clear so only the mask is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CFG_CTX; c++) begin
                for (int s = 0; s < STAGE_NUM; s++) begin
                    mem[c][s] <= '0;
                end
            end
        end else if (wr_ok) begin
            mem[wr_ctx][wr_stage] <= wr_bits;
        end
    end

    // Written-stage masks; a clear wipes the whole context at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CFG_CTX; c++) begin
                mask[c] <= '0;
            end
        end else if (clr_en) begin
            mask[clr_ctx] <= '0;
        end else if (wr_ok) begin
            mask[wr_ctx][wr_stage] <= 1'b1;
        end
    end

    // One read port per stage, each addressed by the context entering that stage.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < STAGE_NUM; k++) begin
            rd_data[k] = mem[rd_ctx[k]][k];
        end
    end

    // Ready flags come straight from the registered masks, so a write is
    // visible to admission on the following cycle.
    always_comb begin
        ctx_ready = '0;
        for (int c = 0; c < CFG_CTX; c++) begin
            ctx_ready[c] = (ctx_state(mask[c]) == CTX_READY);
        end
    end

endmodule

// File: rtl/benes_route_ctrl.sv
// Route controller: admits tagged vectors and drives per-stage switch settings.
// Latency: stage k setting in cycle T+1+k after admission at T; out_valid at T+1+STAGE_NUM.
// Backpressure: in_ready only from context readiness; cfg_ready low while the context is in use.
module benes_route_ctrl
    import benes_route_ctrl_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic                                 cfg_clear,
    input  logic [CTX_W-1:0]                     cfg_ctx,
    input  logic [STAGE_W-1:0]                   cfg_stage,
    input  logic [SWITCH_NUM-1:0]                cfg_bits,
    output logic                                 cfg_err,
    output logic [CFG_CTX-1:0]                   ctx_ready,
    input  logic                                 in_valid,
    input  logic [CTX_W-1:0]                     in_ctx,
    output logic                                 in_ready,
    output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] stage_set,
    output logic                                 out_valid,
    output logic [CTX_W-1:0]                     out_ctx
);

    logic                                 in_fire;
    logic                                 cfg_fire;
    logic                                 cfg_wr;
    logic                                 cfg_clr;
    inflight_t                            inflight [CFG_CTX];
    pipe_ent_t                            pipe     [PIPE_DEPTH];
    pipe_ent_t                            pipe_nxt [PIPE_DEPTH];
    logic [STAGE_NUM-1:0][CTX_W-1:0]      rd_ctx;
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] rd_data;

    benes_cfg_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (cfg_wr),
        .wr_ctx    (cfg_ctx),
        .wr_stage  (cfg_stage),
        .wr_bits   (cfg_bits),
        .clr_en    (cfg_clr),
        .clr_ctx   (cfg_ctx),
        .rd_ctx    (rd_ctx),
        .rd_data   (rd_data),
        .ctx_ready (ctx_ready)
    );

    // Handshakes: a context is writable only when nothing is in flight on it
    // and no vector for it is being admitted this cycle (admission wins).
    always_comb begin
        in_ready  = ctx_ready[in_ctx];
        in_fire   = in_valid && in_ready;
        cfg_ready = (inflight[cfg_ctx] == '0) && !(in_fire && (in_ctx == cfg_ctx));
        cfg_fire  = cfg_valid && cfg_ready;
        cfg_wr    = cfg_fire && !cfg_clear;
        cfg_clr   = cfg_fire && cfg_clear;
    end

    // Value each pipeline entry takes at the next edge; idle slots carry a
    // zero tag so out_ctx stays clean between vectors.
    always_comb begin
        pipe_nxt[0] = '0;
        if (in_fire) begin
            pipe_nxt[0] = '{vld: 1'b1, ctx: in_ctx};
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            pipe_nxt[k] = pipe[k-1];
        end
    end

    // Read ports look up the context about to occupy each stage, so the
    // registered setting lines up with the vector in that same cycle.
    always_comb begin
        rd_ctx = '0;
        for (int k = 0; k < STAGE_NUM; k++) begin
            rd_ctx[k] = pipe_nxt[k].ctx;
        end
    end

    // Context pipeline shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe[k] <= pipe_nxt[k];
            end
        end
    end

    // Registered switch settings; empty stages fall back to bar (all zero).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_set <= '0;
        end else begin
            for (int k = 0; k < STAGE_NUM; k++) begin
                stage_set[k] <= pipe_nxt[k].vld ? rd_data[k] : '0;
            end
        end
    end

    // Per-context in-flight counters; simultaneous admit and retire cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CFG_CTX; c++) begin
                inflight[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CFG_CTX; c++) begin
                if (in_fire && (in_ctx == CTX_W'(c)) &&
                    !(out_valid && (out_ctx == CTX_W'(c)))) begin
                    inflight[c] <= inflight[c] + CNT_W'(1);
                end else if (!(in_fire && (in_ctx == CTX_W'(c))) &&
                             out_valid && (out_ctx == CTX_W'(c))) begin
                    inflight[c] <= inflight[c] - CNT_W'(1);
                end
            end
        end
    end

    // Sticky flag for writes aimed past the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (cfg_wr && !stage_in_range(cfg_stage)) begin
            cfg_err <= 1'b1;
        end
    end

    assign out_valid = pipe[PIPE_DEPTH-1].vld;
    assign out_ctx   = pipe[PIPE_DEPTH-1].ctx;

endmodule
